// File: rtl/div_unit.sv
// Sequential 32-bit divider for the EX stage: restoring radix-2, one quotient bit
// per cycle, signed/unsigned, with divide-by-zero shortcut and pipeline flush.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        annul,
    output logic [63:0] div_result,
    output logic        div_ready,
    output logic        stall_req
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [64:0] rq_q, rq_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [63:0] result_q, result_d;

    logic [64:0] shifted;
    logic [32:0] diff;
    logic [64:0] step_rq;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] dividend_mag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            rq_q     <= '0;
            dvsr_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rq_q     <= rq_d;
            dvsr_q   <= dvsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        // One restoring step: shift, trial-subtract from the upper 33 bits, keep or restore.
        shifted = rq_q << 1;
        diff    = shifted[64:32] - {1'b0, dvsr_q};
        if (diff[32]) begin
            step_rq = shifted;
        end else begin
            step_rq = {diff, shifted[31:1], 1'b1};
        end
        quo_fix = q_neg_q ? (~step_rq[31:0] + 32'd1)  : step_rq[31:0];
        rem_fix = r_neg_q ? (~step_rq[63:32] + 32'd1) : step_rq[63:32];

        dividend_mag = (div_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rq_d     = rq_q;
        dvsr_d   = dvsr_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (div_start && !annul) begin
                    dvsr_d   = (div_signed && divisor[31]) ? (~divisor + 32'd1) : divisor;
                    rq_d     = {33'd0, dividend_mag};
                    q_neg_d  = div_signed & (dividend[31] ^ divisor[31]);
                    r_neg_d  = div_signed & dividend[31];
                    count_d  = '0;
                    result_d = '0;
                    state_d  = (divisor == 32'd0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                result_d = '0;
                state_d  = S_END;
            end
            S_ON: begin
                rq_d    = step_rq;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    result_d = {rem_fix, quo_fix};
                    state_d  = S_END;
                end
            end
            S_END: begin
                if (!div_start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush overrides every other transition.
        if (annul) begin
            state_d = S_IDLE;
            count_d = '0;
        end
    end

    assign div_ready  = (state_q == S_END);
    assign div_result = div_ready ? result_q : 64'h0;
    assign stall_req  = div_start & ~div_ready & ~annul;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus random operands,
// checked against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stall_req;

    always #5 clk = ~clk;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .div_start  (div_start),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .annul      (annul),
        .div_result (div_result),
        .div_ready  (div_ready),
        .stall_req  (stall_req)
    );

    typedef struct {
        logic [63:0] res;
        int unsigned start_cyc;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        prev_ready = 1'b0;
    logic [63:0] last_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: C-style truncating division, remainder takes dividend sign.
    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sd, q, r;
        if (b == 32'd0) return 64'h0;
        if (sg) begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sd = longint'({32'd0, b});
        end
        q = sa / sd;
        r = sa % sd;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic push_exp(input logic sg, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.res      = model(sg, a, b);
        e.start_cyc = cyc;
        e.lat      = (b == 32'd0) ? 2 : 33;
        last_exp   = e.res;
        sb.push_back(e);
    endtask

    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b, input bit push);
        @(posedge clk); #1;
        div_start  = 1'b1;
        div_signed = sg;
        dividend   = a;
        divisor    = b;
        if (push) push_exp(sg, a, b);
    endtask

    task automatic finish_op(input int hold, input bit scramble, input bit chk_stall);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!div_ready) begin
                if (chk_stall) check("stall_busy", 64'(stall_req), 64'd1);
                if (scramble && n > 1) begin
                    dividend   = $urandom;
                    divisor    = $urandom;
                    div_signed = 1'($urandom);
                end
            end
        end while (!div_ready && n < 100);
        check("ready_seen", 64'(div_ready), 64'd1);
        check("stall_end", 64'(stall_req), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_ready", 64'(div_ready), 64'd1);
            check("hold_result", div_result, last_exp);
        end
        @(posedge clk); #1;
        div_start = 1'b0;
        @(negedge clk);
        check("drop_stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        check("idle_ready", 64'(div_ready), 64'd0);
        check("idle_result", div_result, 64'h0);
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (div_ready && !prev_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got ready=1 result=%h required no result (t=%0t)",
                         div_result, $time);
            end else begin
                mon_e = sb.pop_front();
                check("result", div_result, mon_e.res);
                check("latency", 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
            end
        end
        prev_ready = div_ready;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        sg;
        logic [31:0] a, b;

        rst = 1'b0; div_start = 1'b0; div_signed = 1'b0;
        dividend = '0; divisor = '0; annul = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(div_ready), 64'd0);
        check("rst_result", div_result, 64'h0);
        check("rst_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        issue(1'b0, 32'd100, 32'd7, 1'b1);
        finish_op(1, 1'b0, 1'b1);

        issue(1'b1, 32'hFFFF_FFF9, 32'h2, 1'b1);
        finish_op(1, 1'b1, 1'b1);

        issue(1'b0, 32'h1234, 32'h0, 1'b1);
        finish_op(1, 1'b0, 1'b1);

        // Flush in cycle 10 of a running divide.
        issue(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(negedge clk);
        check("annul_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        annul = 1'b0;
        div_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("annul_no_ready", 64'(div_ready), 64'd0);
        end
        issue(1'b0, 32'd1000, 32'd33, 1'b1);
        finish_op(0, 1'b0, 1'b1);

        // Reset in cycle 15, release with start still held.
        issue(1'b0, 32'd12345, 32'd67, 1'b0);
        repeat (15) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 64'(div_ready), 64'd0);
        check("midrst_result", div_result, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        push_exp(1'b0, 32'd12345, 32'd67);
        finish_op(0, 1'b0, 1'b1);

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        finish_op(5, 1'b0, 1'b1);

        for (int k = 0; k < 40; k++) begin
            sg = 1'($urandom);
            a  = ($urandom % 8 == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom % 8)
                0:       b = 32'h0;
                1:       b = 32'h1;
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom % 16;
                default: b = $urandom;
            endcase
            issue(sg, a, b, 1'b1);
            finish_op($urandom % 3, 1'b1, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port div_start, input, 1 bit: EX-stage divide request, held high by the pipeline until the result is consumed.
REQ-004 SHALL have port div_signed, input, 1 bit: 1 selects signed (DIV), 0 selects unsigned (DIVU); sampled with div_start in IDLE.
REQ-005 SHALL have port dividend, input, 32 bits: numerator, sampled with div_start in IDLE.
REQ-006 SHALL have port divisor, input, 32 bits: denominator, sampled with div_start in IDLE.
REQ-007 SHALL have port annul, input, 1 bit: flush; aborts any operation in progress.
REQ-008 SHALL have port div_result, output, 64 bits: {remainder[63:32], quotient[31:0]}.
REQ-009 SHALL have port div_ready, output, 1 bit: div_result valid.
REQ-010 SHALL have port stall_req, output, 1 bit: EX stall request, driven to the stall controller's ex_stop input.

Function
REQ-011 SHALL implement a four-state FSM: IDLE, BYZERO, ON, END.
REQ-012 SHALL, in IDLE with div_start=1 and annul=0, latch operands and div_signed; go to BYZERO if divisor==0, else ON with iteration count 0.
REQ-013 SHALL, in IDLE with div_start=0 or annul=1, stay in IDLE.
REQ-014 SHALL, in signed mode, convert negative operands to magnitudes at latch time and record quotient sign (dividend[31]^divisor[31]) and remainder sign (dividend[31]).
REQ-015 SHALL, in ON, perform one restoring radix-2 step per cycle on a 65-bit partial-remainder/quotient register: shift left 1, trial-subtract divisor magnitude from the upper 33 bits, keep the difference and set quotient bit 1 if non-negative, else restore and set bit 0.
REQ-016 SHALL perform exactly 32 steps (count 0..31), moving to END on the edge that completes step 31 and applying sign correction (two's-complement negate) to quotient/remainder as recorded.
REQ-017 SHALL, in BYZERO, move to END after one cycle with div_result = 64'h0.
REQ-018 SHALL hold div_ready=1 and div_result stable in END while div_start=1; go to IDLE when div_start=0.
REQ-019 SHALL drive div_ready=0 and div_result=64'h0 in every state except END.
REQ-020 SHALL drive stall_req = div_start & ~div_ready & ~annul, combinationally.
REQ-021 SHALL, on annul=1 in BYZERO, ON or END, return to IDLE on the next edge; annul has priority over every other transition.
REQ-022 SHALL, with start high at cycle 0 in IDLE, give non-zero-divisor latency of div_ready=1 in cycle 33 and zero-divisor latency of div_ready=1 in cycle 2.
REQ-023 SHALL produce quotient 32'h80000000 and remainder 0 for signed 32'h80000000 / 32'hFFFFFFFF, with no trap.
REQ-024 SHALL ignore changes on dividend, divisor and div_signed after latching.

Reset
REQ-025 SHALL, while rst=0, asynchronously force IDLE, iteration count 0, internal registers 0, div_ready=0 and div_result=64'h0.
REQ-026 SHALL, on rst asserted mid-operation, discard the operation; after release, an operation begins only on a new IDLE sample of div_start.

Verification
REQ-027 SHALL cover unsigned 100/7 (div_signed=0): required div_result=64'h00000002_0000000E, div_ready in cycle 33, stall_req high cycles 0..32 and low from cycle 33.
REQ-028 SHALL cover signed -7/2 (32'hFFFFFFF9/32'h2): required div_result=64'hFFFFFFFF_FFFFFFFD.
REQ-029 SHALL cover divisor=0, dividend=32'h1234: required BYZERO then END, div_result=64'h0, div_ready in cycle 2.
REQ-030 SHALL cover annul pulsed in cycle 10 of an ON operation: required IDLE next cycle, div_ready never asserts, stall_req=0 during annul; a following start runs the full 33-cycle latency.
REQ-031 SHALL cover rst low in cycle 15 of an operation, then release with div_start held: required outputs 0 during reset and a fresh 33-cycle operation after release.
REQ-032 SHALL cover signed 32'h80000000/32'hFFFFFFFF: required div_result=64'h00000000_80000000; div_start held high 5 cycles in END requires a stable result, and dropping div_start requires IDLE next cycle.
